// File: rtl/ascon_pack.sv
// Shared constants and types for the ASCON permutation control path.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } perm_state_t;

  localparam logic [3:0] ROUND_LAST = 4'd11;
  localparam logic [3:0] PA_START   = 4'd0;
  localparam logic [3:0] PB_START   = 4'd4;

  localparam logic [7:0] RC_TABLE [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  // Indices above ROUND_LAST are unreachable; map them to zero rather than index out of range.
  function automatic logic [7:0] rc_lookup(input logic [3:0] idx);
    if (idx <= ROUND_LAST) begin
      return RC_TABLE[idx];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/compteur_double_init.sv
// Round counter with two selectable load values (p^a and p^b start indices).
module compteur_double_init
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       en_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  output logic [3:0] cpt_o
);

  logic [3:0] cpt_q;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      cpt_q <= 4'd0;
    end else if (en_i) begin
      if (init_a_i) begin
        cpt_q <= PA_START;
      end else if (init_b_i) begin
        cpt_q <= PB_START;
      end else begin
        cpt_q <= cpt_q + 4'd1;
      end
    end
  end

  assign cpt_o = cpt_q;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Permutation control FSM: sequences p^a / p^b rounds through the shared round counter.
module ascon_perm_ctrl
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       ready_o,
  output logic       en_perm_o,
  output logic       sel_init_o,
  output logic [3:0] cpt_o,
  output logic [7:0] rc_o,
  output logic       done_o
);

  perm_state_t state_q, state_d;
  logic        first_q, first_d;
  logic        cnt_en, cnt_init_a, cnt_init_b;
  logic [3:0]  cpt;

  compteur_double_init u_cnt (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (cnt_en),
    .init_a_i (cnt_init_a),
    .init_b_i (cnt_init_b),
    .cpt_o    (cpt)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    first_d    = 1'b0;
    cnt_en     = 1'b0;
    cnt_init_a = 1'b0;
    cnt_init_b = 1'b0;
    ready_o    = 1'b0;
    en_perm_o  = 1'b0;
    sel_init_o = 1'b0;
    rc_o       = 8'h00;
    done_o     = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        // Abort wins over start: no counter load, stay idle.
        if (start_i && !abort_i) begin
          cnt_en     = 1'b1;
          cnt_init_a = ~mode_i;
          cnt_init_b = mode_i;
          first_d    = 1'b1;
          state_d    = ROUND;
        end
      end
      ROUND: begin
        en_perm_o  = 1'b1;
        sel_init_o = first_q;
        rc_o       = rc_lookup(cpt);
        if (abort_i) begin
          state_d = IDLE;
        end else if (cpt < ROUND_LAST) begin
          cnt_en = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpt_o = cpt;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: expected per-cycle outputs queued, popped as cycles elapse.
module tb_ascon_perm_ctrl;

  typedef struct packed {
    logic       ready;
    logic       en_perm;
    logic       sel_init;
    logic [3:0] cpt;
    logic [7:0] rc;
    logic       done;
  } obs_t;

  localparam logic [7:0] RC_REF [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic       abort;
  logic       ready;
  logic       en_perm;
  logic       sel_init;
  logic [3:0] cpt;
  logic [7:0] rc;
  logic       done;

  int   n_checks;
  int   n_fails;
  obs_t exp_q[$];
  obs_t obs;
  obs_t exp;

  ascon_perm_ctrl dut (
    .clock_i    (clk),
    .resetb_i   (rst_n),
    .start_i    (start),
    .mode_i     (mode),
    .abort_i    (abort),
    .ready_o    (ready),
    .en_perm_o  (en_perm),
    .sel_init_o (sel_init),
    .cpt_o      (cpt),
    .rc_o       (rc),
    .done_o     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb obs = '{ready, en_perm, sel_init, cpt, rc, done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t mk_idle(input logic [3:0] c);
    return '{1'b1, 1'b0, 1'b0, c, 8'h00, 1'b0};
  endfunction

  function automatic obs_t mk_round(input int i, input logic first);
    return '{1'b0, 1'b1, first, 4'(i), RC_REF[i], 1'b0};
  endfunction

  // Rounds from first index to 11, then the DONE cycle.
  task automatic push_run(input logic m);
    int first_idx;
    first_idx = m ? 4 : 0;
    for (int i = first_idx; i <= 11; i++) exp_q.push_back(mk_round(i, i == first_idx));
    exp_q.push_back('{1'b0, 1'b0, 1'b0, 4'd11, 8'h00, 1'b1});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    abort = 1'b0;
    #3;
    exp = mk_idle(4'd0);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL reset: got %h want %h", obs, exp);
      n_fails++;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL reset_release: got %h want %h", obs, exp);
      n_fails++;
    end
  endtask

  task automatic test_pa();
    start = 1'b1;
    mode  = 1'b0;
    push_run(1'b0);
    exp_q.push_back(mk_idle(4'd11));
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL pa cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
  endtask

  task automatic test_pb();
    start = 1'b1;
    mode  = 1'b1;
    push_run(1'b1);
    exp_q.push_back(mk_idle(4'd11));
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL pb cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
  endtask

  task automatic test_start_held();
    start = 1'b1;
    mode  = 1'b1;
    push_run(1'b1);
    exp_q.push_back(mk_idle(4'd11));
    push_run(1'b1);
    exp_q.push_back(mk_idle(4'd11));
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 11) start = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL start_held cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
  endtask

  task automatic test_abort();
    start = 1'b1;
    mode  = 1'b0;
    for (int i = 0; i <= 6; i++) exp_q.push_back(mk_round(i, i == 0));
    for (int c = 8; c <= 10; c++) exp_q.push_back(mk_idle(4'd6));
    push_run(1'b1);
    exp_q.push_back(mk_idle(4'd11));
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      abort = (c == 7);
      if (c == 10) begin
        start = 1'b1;
        mode  = 1'b1;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL abort cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_abort_with_start();
    start = 1'b1;
    abort = 1'b1;
    mode  = 1'b0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    exp = mk_idle(4'd11);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL abort_with_start: got %h want %h", obs, exp);
      n_fails++;
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    mode  = 1'b0;
    for (int i = 0; i <= 8; i++) exp_q.push_back(mk_round(i, i == 0));
    for (int c = 1; c <= 9; c++) begin
      tick();
      start = 1'b0;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL async_reset_run cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp = mk_idle(4'd0);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL async_reset_immediate: got %h want %h", obs, exp);
      n_fails++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL async_reset_after: got %h want %h", obs, exp);
      n_fails++;
    end
  endtask

  task automatic test_back_to_back();
    int sel_count;
    sel_count = 0;
    start = 1'b1;
    mode  = 1'b0;
    push_run(1'b0);
    exp_q.push_back(mk_idle(4'd11));
    push_run(1'b1);
    exp_q.push_back(mk_idle(4'd11));
    for (int c = 1; c <= 24; c++) begin
      tick();
      start = (c == 14);
      mode  = (c == 14);
      if (sel_init === 1'b1) sel_count++;
      exp = exp_q.pop_front();
      n_checks++;
      if (obs !== exp) begin
        $display("FAIL back_to_back cycle %0d: got %h want %h", c, obs, exp);
        n_fails++;
      end
    end
    n_checks++;
    if (sel_count !== 2) begin
      $display("FAIL back_to_back_sel_count: got %0d want 2", sel_count);
      n_fails++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_pa();
    test_pb();
    test_start_held();
    test_abort();
    test_abort_with_start();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
